// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Round-robin arbiter that shares a single-port main memory between NUM_REQ
//   masters (for example an I-cache and a D-cache). It accepts one read or
//   write at a time, drives the memory's level req/ack handshake, and returns
//   the result with a one-cycle response pulse to the requester it granted.
//
//   Optional feature macro: MEM_ARB_TIMEOUT_EN
//     defined   : a transaction that sees no mem_ack for TIMEOUT_CYCLES ISSUE
//                 cycles is aborted and answered with resp_err=1, resp_rdata=0.
//     undefined : ISSUE waits for mem_ack indefinitely; resp_err is tied 0.
//
// Ports
//   clk, reset        clock (posedge) and synchronous active-high reset
//   req_valid[i]      requester i has a request; fields held until req_ready[i]
//   req_write[i]      1 = write, 0 = read
//   req_addr/wdata    per-requester 32-bit fields, requester i at [32*i +: 32]
//   req_ready         one-hot accept pulse, combinational, only in IDLE
//   resp_valid        one-hot one-cycle completion pulse (registered)
//   resp_rdata        read data (0 for writes), held between responses
//   resp_err          timeout abort flag, held between responses
//   mem_read_req      registered level request to main memory (read)
//   mem_write_req     registered level request to main memory (write)
//   mem_addr/wdata    registered address / write data to main memory
//   mem_rdata         read data from main memory
//   mem_ack           acknowledge from main memory (registered on its side)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic                   mem_read_req,
  output logic                   mem_write_req,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_ack
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [GW-1:0]      r_last;        // most recent grant; also the owner of the current transaction
  logic               r_write;
  logic               r_mem_read_req;
  logic               r_mem_write_req;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [31:0]        r_resp_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  logic               r_resp_err;
  logic [7:0]         r_tmo_cnt;
`endif

  logic               w_any;
  logic [GW-1:0]      w_grant;
  logic [GW-1:0]      w_idx;
  logic               w_sel_write;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_sel_wdata;

  // Round-robin pick: scan starting one past the last grant and wrap, so the
  // previous winner is considered last and no holder of req_valid starves.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so
    // no path leaves it unassigned and no latch is inferred.
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = GW'((int'(r_last) + k) % NUM_REQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_sel_write = req_write[w_grant];
  assign w_sel_addr  = req_addr[{w_grant, 5'b0} +: 32];
  assign w_sel_wdata = req_wdata[{w_grant, 5'b0} +: 32];

  assign req_ready = (r_state == ST_IDLE && w_any) ? (NUM_REQ'(1) << w_grant) : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state         <= ST_IDLE;
      r_last          <= GW'(NUM_REQ - 1);
      r_write         <= 1'b0;
      r_mem_read_req  <= 1'b0;
      r_mem_write_req <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_resp_valid    <= '0;
      r_resp_rdata    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_resp_err      <= 1'b0;
      r_tmo_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_resp_valid <= '0;
          if (w_any) begin
            r_last          <= w_grant;
            r_write         <= w_sel_write;
            r_mem_addr      <= w_sel_addr;
            r_mem_wdata     <= w_sel_wdata;
            r_mem_read_req  <= ~w_sel_write;
            r_mem_write_req <= w_sel_write;
            r_state         <= ST_ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
            r_tmo_cnt       <= '0;
`endif
          end
        end

        ST_ISSUE: begin
          if (mem_ack) begin
            // Dropping req on the ack edge means memory sees req for two edges:
            // a write lands twice (idempotent), a read is repeated.
            r_mem_read_req  <= 1'b0;
            r_mem_write_req <= 1'b0;
            r_resp_rdata    <= r_write ? 32'd0 : mem_rdata;
            r_resp_valid    <= NUM_REQ'(1) << r_last;
            r_state         <= ST_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
            r_resp_err      <= 1'b0;
          end else if (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th ISSUE cycle without an ack: abort.
            r_mem_read_req  <= 1'b0;
            r_mem_write_req <= 1'b0;
            r_resp_rdata    <= 32'd0;
            r_resp_err      <= 1'b1;
            r_resp_valid    <= NUM_REQ'(1) << r_last;
            r_state         <= ST_RESP;
          end else begin
            r_tmo_cnt       <= r_tmo_cnt + 8'd1;
`endif
          end
        end

        ST_RESP: begin
          // mem_ack is still high here from the repeated request; ignored.
          r_resp_valid <= '0;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_resp_valid    <= '0;
          r_mem_read_req  <= 1'b0;
          r_mem_write_req <= 1'b0;
          r_state         <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_read_req  = r_mem_read_req;
  assign mem_write_req = r_mem_write_req;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  assign resp_err      = r_resp_err;
`else
  assign resp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Bench for mem_arbiter with a behavioural main memory (word i initialised to
//   i, ack registered one cycle after a request level). Accepted requests push
//   their expected response onto a scoreboard; responses pop and compare index,
//   data, error flag and latency. An independent round-robin model predicts
//   req_ready every cycle a request is pending.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TMO     = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_read_req;
  logic                  mem_write_req;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  mem_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read_req (mem_read_req),
    .mem_write_req(mem_write_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  // Behavioural main memory.
  logic [31:0] mem [64];
  logic        ack_block = 1'b0;
  initial for (int i = 0; i < 64; i++) mem[i] = 32'(i);
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
  end
  always @(posedge clk) begin
    if (!ack_block && (mem_read_req || mem_write_req)) begin
      mem_ack   <= 1'b1;
      mem_rdata <= mem[mem_addr[7:2]];
      if (mem_write_req) mem[mem_addr[7:2]] <= mem_wdata;
    end else begin
      mem_ack <= 1'b0;
    end
  end

  // Scoreboard and reference state.
  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          gcyc;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  int          g_log [$];
  int          g_cyc [$];
  logic [31:0] sb_mem [64];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          tb_last = NUM_REQ - 1;
  bit          tb_idle = 1'b1;
  bit          pend_idle = 1'b0;

  initial for (int i = 0; i < 64; i++) sb_mem[i] = 32'(i);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    int                 g;
    exp_t               e;
    int                 a;
    if (reset) begin
      sb.delete();
      tb_idle   = 1'b1;
      pend_idle = 1'b0;
      tb_last   = NUM_REQ - 1;
    end else begin
      if (pend_idle) begin
        tb_idle   = 1'b1;
        pend_idle = 1'b0;
      end
      exp_ready = '0;
      g = -1;
      if (tb_idle)
        for (int k = 1; k <= NUM_REQ; k++)
          if (g < 0 && req_valid[(tb_last + k) % NUM_REQ]) g = (tb_last + k) % NUM_REQ;
      if (g >= 0) exp_ready[g] = 1'b1;
      if (req_valid != '0 || req_ready != '0) begin
        n_vec++;
        if (req_ready !== exp_ready) begin
          n_err++;
          $display("FAIL req_ready @cyc %0d: got %b required %b", cyc, req_ready, exp_ready);
        end
      end
      if (g >= 0) begin
        a      = int'(req_addr[g*32 +: 32] >> 2) % 64;
        e.idx  = g;
        e.gcyc = cyc;
        e.lat  = 3;
        e.err  = 1'b0;
        if (ack_block) begin
          e.rdata = 32'd0;
          e.err   = 1'b1;
          e.lat   = TMO + 1;
        end else if (req_write[g]) begin
          sb_mem[a] = req_wdata[g*32 +: 32];
          e.rdata   = 32'd0;
        end else begin
          e.rdata = sb_mem[a];
        end
        sb.push_back(e);
        g_log.push_back(g);
        g_cyc.push_back(cyc);
        tb_last = g;
        tb_idle = 1'b0;
      end
      if (resp_valid != '0) begin
        pend_idle = 1'b1;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_resp @cyc %0d: got resp_valid=%b required none", cyc, resp_valid);
        end else begin
          e = sb.pop_front();
          if (resp_valid !== (NUM_REQ'(1) << e.idx)) begin
            n_err++;
            $display("FAIL resp_valid: got %b required %b", resp_valid, NUM_REQ'(1) << e.idx);
          end
          n_vec++;
          if (resp_rdata !== e.rdata) begin
            n_err++;
            $display("FAIL resp_rdata: got %h required %h", resp_rdata, e.rdata);
          end
          n_vec++;
          if (resp_err !== e.err) begin
            n_err++;
            $display("FAIL resp_err: got %b required %b", resp_err, e.err);
          end
          n_vec++;
          if (cyc - e.gcyc != e.lat) begin
            n_err++;
            $display("FAIL resp_latency: got %0d required %0d", cyc - e.gcyc, e.lat);
          end
        end
      end
    end
  end

  // Raise one request, wait for its accept, then drop req_valid after the edge.
  task automatic do_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    req_write[i]          = w;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
    req_valid[i]          = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL grant_wait req%0d: got no req_ready required req_ready within 100 cycles", i);
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL resp_wait: got %0d outstanding required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_vec++;
      if ({req_ready, resp_valid, resp_err, mem_read_req, mem_write_req} !== '0 ||
          mem_addr !== 32'd0 || mem_wdata !== 32'd0 || resp_rdata !== 32'd0) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: got rdy=%b rv=%b err=%b rq=%b wq=%b addr=%h wd=%h rd=%h required all 0",
                 k, req_ready, resp_valid, resp_err, mem_read_req, mem_write_req, mem_addr, mem_wdata, resp_rdata);
      end
    end
  endtask

  task automatic test_read_after_reset();
    do_req(0, 1'b0, 32'h8, 32'h0);
    wait_idle();
    n_vec++;
    if (resp_rdata !== 32'd2) begin
      n_err++;
      $display("FAIL first_read: got %h required 00000002", resp_rdata);
    end
  endtask

  task automatic test_write_read();
    do_req(1, 1'b1, 32'hC, 32'hDEADBEEF);
    wait_idle();
    n_vec++;
    if (resp_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL write_rdata: got %h required 00000000", resp_rdata);
    end
    do_req(1, 1'b0, 32'hC, 32'h0);
    wait_idle();
    n_vec++;
    if (resp_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL readback: got %h required deadbeef", resp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    int want;
    g_log.delete();
    g_cyc.delete();
    req_write = 2'b10;
    req_addr  = {32'h14, 32'h4};
    req_wdata = {32'hA5A5_0001, 32'h0};
    req_valid = 2'b11;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (g_log.size() >= 6) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();
    n_vec++;
    if (!done || g_log.size() != 6) begin
      n_err++;
      $display("FAIL b2b_count: got %0d grants required 6", g_log.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        want = k % 2;
        n_vec++;
        if (g_log[k] != want) begin
          n_err++;
          $display("FAIL b2b_order[%0d]: got %0d required %0d", k, g_log[k], want);
        end
        if (k > 0) begin
          n_vec++;
          if (g_cyc[k] - g_cyc[k-1] != 4) begin
            n_err++;
            $display("FAIL b2b_spacing[%0d]: got %0d required 4", k, g_cyc[k] - g_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_req(0, 1'b0, 32'h18, 32'h0);
    // Now in ISSUE; abandon the transaction.
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    n_vec++;
    if (mem_read_req !== 1'b0 || mem_write_req !== 1'b0 || resp_valid !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got rq=%b wq=%b rv=%b required 0 0 00", mem_read_req, mem_write_req, resp_valid);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid != '0) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL reset_mid_resp: got %0d pulses required 0", seen);
    end
    do_req(1, 1'b0, 32'h18, 32'h0);
    wait_idle();
    n_vec++;
    if (resp_rdata !== 32'd6) begin
      n_err++;
      $display("FAIL post_reset_read: got %h required 00000006", resp_rdata);
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    ack_block = 1'b1;
    do_req(0, 1'b0, 32'h8, 32'h0);
    wait_idle();
    ack_block = 1'b0;
    n_vec++;
    if (resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL timeout_hold: got err=%b rdata=%h required 1 00000000", resp_err, resp_rdata);
    end
    do_req(1, 1'b0, 32'h8, 32'h0);
    wait_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
